// File: rtl/mig_ui_arbiter_pkg.sv
// Shared types and encodings for the MIG UI two-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mig_ui_arbiter_pkg;

    // MIG app_cmd encodings
    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;

    // Requester index: 0 or 1
    typedef logic req_id_t;

    // Arbiter control states
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/mig_ui_tag_fifo.sv
// In-order FIFO of requester ids for reads that the MIG has accepted but not yet returned.
// Latency: pushed id becomes visible at pop_dat once it reaches the head; pop_dat is combinational from the head.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop is ignored when empty.
module mig_ui_tag_fifo
    import mig_ui_arbiter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  req_id_t push_dat,
    input  logic    pop,
    output req_id_t pop_dat,
    output logic    full,
    output logic    empty
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    req_id_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/mig_ui_arbiter.sv
// Two-requester round-robin front end for a MIG user interface, routing read data back in order.
// Latency: app_en one cycle after req_ready; rsp*_valid one cycle after app_rd_data_valid.
// Backpressure: req_ready low during a command, before/without calibration, and for reads when the tag FIFO is full.
module mig_ui_arbiter
    import mig_ui_arbiter_pkg::*;
#(
    parameter  int ADDR_BITS = 24,
    parameter  int DATA_BITS = 128,
    parameter  int TAG_DEPTH = 16,
    localparam int MASK_BITS = DATA_BITS / 8
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_write,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [DATA_BITS-1:0] req0_wdata,
    input  logic [MASK_BITS-1:0] req0_wmask,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_write,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [DATA_BITS-1:0] req1_wdata,
    input  logic [MASK_BITS-1:0] req1_wmask,

    output logic                 rsp0_valid,
    output logic [DATA_BITS-1:0] rsp0_data,
    output logic                 rsp1_valid,
    output logic [DATA_BITS-1:0] rsp1_data,

    input  logic                 init_calib_complete,

    input  logic                 app_rdy,
    output logic                 app_en,
    output logic [2:0]           app_cmd,
    output logic [ADDR_BITS-1:0] app_addr,

    input  logic                 app_wdf_rdy,
    output logic                 app_wdf_wren,
    output logic                 app_wdf_end,
    output logic [DATA_BITS-1:0] app_wdf_data,
    output logic [MASK_BITS-1:0] app_wdf_mask,

    input  logic [DATA_BITS-1:0] app_rd_data,
    input  logic                 app_rd_data_valid,

    output logic                 rsp_underflow
);

    // Control state
    state_t               state;
    req_id_t              last_grant;
    req_id_t              id_q;
    logic                 wr_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [MASK_BITS-1:0] wmask_q;
    logic                 cmd_done;
    logic                 wdf_done;
    logic                 rst_q;

    // Read return state
    logic                 rsp0_vld_q;
    logic                 rsp1_vld_q;
    logic [DATA_BITS-1:0] rsp_dat_q;
    logic                 underflow_q;

    // Arbitration and handshake terms
    logic                 blocked;
    logic                 elig0;
    logic                 elig1;
    logic                 grant0;
    logic                 grant1;
    logic                 sel_write;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0] sel_wdata;
    logic [MASK_BITS-1:0] sel_wmask;
    logic                 issue;
    logic                 cmd_fire;
    logic                 wdf_fire;

    // Tag FIFO interface
    logic                 tag_push;
    logic                 tag_pop;
    req_id_t              tag_head;
    logic                 tag_full;
    logic                 tag_empty;

    // No grants while in reset, in the first cycle after it, or before calibration.
    assign blocked = reset || rst_q || !init_calib_complete;

    assign elig0 = (state == IDLE) && !blocked && req0_valid && (req0_write || !tag_full);
    assign elig1 = (state == IDLE) && !blocked && req1_valid && (req1_write || !tag_full);

    // Round robin: on contention, the requester not granted last wins.
    assign grant0 = elig0 && (!elig1 || (last_grant == 1'b1));
    assign grant1 = elig1 && (!elig0 || (last_grant == 1'b0));

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_write = grant1 ? req1_write : req0_write;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
    assign sel_wmask = grant1 ? req1_wmask : req0_wmask;

    // Command and write-data channels run independently; each drops once its own handshake completes.
    assign issue        = (state == ISSUE) && !reset;
    assign app_en       = issue && !cmd_done;
    assign app_cmd      = (app_en && !wr_q) ? CMD_READ : CMD_WRITE;
    assign app_addr     = app_en ? addr_q : '0;
    assign app_wdf_wren = issue && !wdf_done;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = app_wdf_wren ? wdata_q : '0;
    assign app_wdf_mask = app_wdf_wren ? wmask_q : '0;

    assign cmd_fire = app_en && app_rdy;
    assign wdf_fire = app_wdf_wren && app_wdf_rdy;

    // Only accepted reads owe a response, so only they take a tag.
    assign tag_push = cmd_fire && !wr_q;
    assign tag_pop  = app_rd_data_valid && !tag_empty;

    mig_ui_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tag_push),
        .push_dat (id_q),
        .pop      (app_rd_data_valid),
        .pop_dat  (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // Remember that reset was seen so outputs stay quiet for one more cycle.
    always_ff @(posedge clk) begin
        rst_q <= reset;
    end

    // Arbiter FSM: latch the granted request, then hold it on the MIG until both channels complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cmd_done   <= 1'b0;
            wdf_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        state      <= ISSUE;
                        last_grant <= grant1;
                        id_q       <= grant1;
                        wr_q       <= sel_write;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        wmask_q    <= sel_wmask;
                        cmd_done   <= 1'b0;
                        // Reads have no data beat, so their write-data channel starts out complete.
                        wdf_done   <= !sel_write;
                    end
                end
                ISSUE: begin
                    if (cmd_done && wdf_done) begin
                        state    <= IDLE;
                        cmd_done <= 1'b0;
                        wdf_done <= 1'b0;
                    end else begin
                        if (cmd_fire) begin
                            cmd_done <= 1'b1;
                        end
                        if (wdf_fire) begin
                            wdf_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read return: steer the data to the requester at the head of the tag FIFO; flag returns nobody asked for.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_vld_q  <= 1'b0;
            rsp1_vld_q  <= 1'b0;
            rsp_dat_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            rsp0_vld_q <= tag_pop && (tag_head == 1'b0);
            rsp1_vld_q <= tag_pop && (tag_head == 1'b1);
            if (tag_pop) begin
                rsp_dat_q <= app_rd_data;
            end
            if (app_rd_data_valid && tag_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign rsp0_valid    = rsp0_vld_q && !reset;
    assign rsp1_valid    = rsp1_vld_q && !reset;
    assign rsp0_data     = reset ? '0 : rsp_dat_q;
    assign rsp1_data     = reset ? '0 : rsp_dat_q;
    assign rsp_underflow = underflow_q && !reset;

endmodule
